fft_stage_sequencer_agu: RTL and testbench

- Parametrised successor to the single-stage FFT address generator.
- Sequences every radix-2 stage of an in-place FFT internally.
- FFT size is selectable at run time, from 4 points up to 2^LOG2N_MAX points.
- Adds a stall handshake, delayed write-back addresses aligned to the butterfly pipeline, and an optional inter-stage hazard gap.
- Sits between the FFT controller (start/done) and the dual-port sample RAM, twiddle ROM and butterfly unit.

---
 rtl/fft_stage_sequencer_agu.sv | 173 +++++++++++++++++
 tb/tb_fft_stage_sequencer_agu.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer_agu.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fft_stage_sequencer_agu - multi-stage in-place radix-2 FFT address sequencer (rev 1.0)
// -----------------------------------------------------------------------------
module fft_stage_sequencer_agu #(
  parameter int LOG2N_MAX  = 10,
  parameter int WB_LATENCY = 3,
  parameter int STAGE_GAP  = 1,
  localparam int AW  = LOG2N_MAX - 1,
  localparam int LNW = $clog2(LOG2N_MAX + 1),
  localparam int SW  = $clog2(LOG2N_MAX)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [LNW-1:0] log2n,
  input  logic           stall,
  output logic           busy,
  output logic           done,
  output logic           rd_valid,
  output logic [AW-1:0]  rd_addr,
  output logic [AW-1:0]  tw_addr,
  output logic [1:0]     ctrl,
  output logic           even_odd,
  output logic [SW-1:0]  stage,
  output logic           wr_valid,
  output logic [AW-1:0]  wr_addr
);

  localparam int WCW = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [AW-1:0]   cnt, cnt_max;
  logic [SW-1:0]   width, width_in;
  logic [LNW-1:0]  size_clamped;
  logic [WCW-1:0]  wcnt;
  logic            issue, last_issue, final_stage, wait_done;
  logic [AW:0]     cnt_ext;
  logic [AW-1:0]   rd_calc, tw_calc, shifted, shifted_rev;
  logic [1:0]      ctrl_calc;
  logic [AW-1:0]   rd_hold, tw_hold;
  logic [1:0]      ctrl_hold;
  logic            eo_hold;
  int              s_int;
  logic [WB_LATENCY-1:0] vpipe;
  logic [AW-1:0]   apipe [WB_LATENCY];

  always_comb begin
    size_clamped = log2n;
    if (log2n < LNW'(2))
      size_clamped = LNW'(2);
    else if (log2n > LNW'(LOG2N_MAX))
      size_clamped = LNW'(LOG2N_MAX);
    width_in = SW'(size_clamped - LNW'(1));
  end

  assign cnt_max     = ~({AW{1'b1}} << width);
  assign issue       = (state == S_RUN) && !stall;
  assign last_issue  = issue && (cnt == cnt_max);
  assign final_stage = (stage == width);
  assign wait_done   = (wcnt == WCW'(WB_LATENCY - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
    rd_valid   = issue;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN: begin
        if (last_issue) begin
          if (final_stage)         next_state = S_DRAIN;
          else if (STAGE_GAP != 0) next_state = S_GAP;
          else                     next_state = S_RUN;
        end
      end
      S_GAP:   if (wait_done) next_state = S_RUN;
      S_DRAIN: if (wait_done) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Read address: low s bits rotated right by one once s >= 2.
  always_comb begin
    cnt_ext = {1'b0, cnt};
    s_int   = int'(stage);
    rd_calc = '0;
    for (int i = 0; i < AW; i++) begin
      if (s_int <= 1 || i >= s_int) rd_calc[i] = cnt_ext[i];
      else if (i == s_int - 1)      rd_calc[i] = cnt_ext[0];
      else                          rd_calc[i] = cnt_ext[i + 1];
    end
    shifted     = cnt >> stage;
    shifted_rev = '0;
    for (int i = 0; i < AW; i++)
      shifted_rev[i] = shifted[AW - 1 - i];
    tw_calc   = shifted_rev >> (SW'(AW) - width);
    ctrl_calc = (stage == '0) ? 2'b10 : {cnt[0], cnt[0]};
  end

  assign rd_addr  = rd_valid ? rd_calc   : rd_hold;
  assign tw_addr  = rd_valid ? tw_calc   : tw_hold;
  assign ctrl     = rd_valid ? ctrl_calc : ctrl_hold;
  assign even_odd = rd_valid ? cnt[0]    : eo_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      stage     <= '0;
      width     <= SW'(1);
      wcnt      <= '0;
      rd_hold   <= '0;
      tw_hold   <= '0;
      ctrl_hold <= '0;
      eo_hold   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt   <= '0;
        stage <= '0;
        width <= width_in;
      end else if (issue) begin
        if (last_issue) begin
          cnt <= '0;
          if (!final_stage) stage <= stage + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if ((state == S_GAP || state == S_DRAIN) && !wait_done) wcnt <= wcnt + 1'b1;
      else                                                    wcnt <= '0;
      if (issue) begin
        rd_hold   <= rd_calc;
        tw_hold   <= tw_calc;
        ctrl_hold <= ctrl_calc;
        eo_hold   <= cnt[0];
      end
    end
  end

  // Shifts every cycle so stalled issues reach the write side as bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe <= '0;
      for (int i = 0; i < WB_LATENCY; i++) apipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_valid;
      apipe[0] <= rd_addr;
      for (int i = 1; i < WB_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
      end
    end
  end

  assign wr_valid = vpipe[WB_LATENCY-1];
  assign wr_addr  = apipe[WB_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer_agu.sv
`default_nettype none
// Bench for fft_stage_sequencer_agu: directed scenarios plus randomized runs against a cycle model.
module tb_fft_stage_sequencer_agu;
  localparam int LMAX = 10;
  localparam int WB   = 3;
  localparam int AW   = LMAX - 1;
  localparam int MAXC = 8192;

  logic clk;
  logic reset_n;
  logic start_a, start_b, stall_a, stall_b;
  logic [3:0] log2n_a, log2n_b;
  logic busy_a, done_a, rdv_a, eo_a, wrv_a;
  logic busy_b, done_b, rdv_b, eo_b, wrv_b;
  logic [AW-1:0] rd_a, tw_a, wa_a, rd_b, tw_b, wa_b;
  logic [1:0] ctrl_a, ctrl_b;
  logic [3:0] stage_a, stage_b;
  logic sel_b;

  int n_cmp, n_fail;
  bit stall_tab [MAXC];
  int exp_rv [MAXC], exp_rd [MAXC], exp_tw [MAXC], exp_ctrl [MAXC], exp_eo [MAXC], exp_stage [MAXC];
  int obs_rv [MAXC], obs_rd [MAXC], obs_tw [MAXC], obs_ctrl [MAXC], obs_eo [MAXC], obs_stage [MAXC];
  int obs_wv [MAXC], obs_wa [MAXC], obs_busy [MAXC], obs_done [MAXC];
  int last_rd [2], last_tw [2], last_ctrl [2], last_eo [2];

  fft_stage_sequencer_agu #(.LOG2N_MAX(LMAX), .WB_LATENCY(WB), .STAGE_GAP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .log2n(log2n_a), .stall(stall_a),
    .busy(busy_a), .done(done_a), .rd_valid(rdv_a), .rd_addr(rd_a), .tw_addr(tw_a),
    .ctrl(ctrl_a), .even_odd(eo_a), .stage(stage_a), .wr_valid(wrv_a), .wr_addr(wa_a));

  fft_stage_sequencer_agu #(.LOG2N_MAX(LMAX), .WB_LATENCY(WB), .STAGE_GAP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .log2n(log2n_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .rd_valid(rdv_b), .rd_addr(rd_b), .tw_addr(tw_b),
    .ctrl(ctrl_b), .even_odd(eo_b), .stage(stage_b), .wr_valid(wrv_b), .wr_addr(wa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_rd(input int r, input int s);
    int low, rot;
    if (s <= 1) return r;
    low = r % (1 << s);
    rot = (low >> 1) | ((low & 1) << (s - 1));
    return (r - low) | rot;
  endfunction

  function automatic int m_tw(input int r, input int s, input int w);
    int x, y;
    x = r >> s;
    y = 0;
    for (int i = 0; i < w; i++)
      if (((x >> i) & 1) == 1) y = y | (1 << (w - 1 - i));
    return y;
  endfunction

  // Issue schedule from the rules: B issues per stage, stalls push issues later,
  // optional WB-cycle gap between stages, WB drain cycles, then the done cycle.
  task automatic build_model(input int lg, input int use_b, output int done_cyc);
    int L, w, B, t;
    L = (lg < 2) ? 2 : ((lg > LMAX) ? LMAX : lg);
    w = L - 1;
    B = 1 << w;
    for (int c = 0; c < MAXC; c++) exp_rv[c] = 0;
    t = 1;
    for (int s = 0; s < L; s++) begin
      for (int r = 0; r < B; r++) begin
        while (stall_tab[t] && t < MAXC - 16) t++;
        exp_rv[t]    = 1;
        exp_rd[t]    = m_rd(r, s);
        exp_tw[t]    = m_tw(r, s, w);
        exp_ctrl[t]  = (s == 0) ? 2 : (((r & 1) == 1) ? 3 : 0);
        exp_eo[t]    = r & 1;
        exp_stage[t] = s;
        t++;
      end
      if (s != L - 1 && use_b == 0) t += WB;
    end
    done_cyc = t + WB;
    for (int c = 0; c <= done_cyc + 3 && c < MAXC; c++) begin
      if (exp_rv[c] == 1) begin
        last_rd[use_b] = exp_rd[c]; last_tw[use_b] = exp_tw[c];
        last_ctrl[use_b] = exp_ctrl[c]; last_eo[use_b] = exp_eo[c];
      end else begin
        exp_rd[c] = last_rd[use_b]; exp_tw[c] = last_tw[use_b];
        exp_ctrl[c] = last_ctrl[use_b]; exp_eo[c] = last_eo[use_b];
      end
    end
  endtask

  task automatic record_run(input int lg, input int use_b, input int ncyc, input int again);
    logic st;
    sel_b = (use_b != 0);
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      st = (t == 0) || (t == again);
      if (use_b != 0) begin
        start_b = st; stall_b = stall_tab[t];
        if (t == 0) log2n_b = 4'(lg); else if (t == 2) log2n_b = 4'($urandom);
      end else begin
        start_a = st; stall_a = stall_tab[t];
        if (t == 0) log2n_a = 4'(lg); else if (t == 2) log2n_a = 4'($urandom);
      end
      @(negedge clk);
      obs_rv[t]    = sel_b ? int'(rdv_b)   : int'(rdv_a);
      obs_rd[t]    = sel_b ? int'(rd_b)    : int'(rd_a);
      obs_tw[t]    = sel_b ? int'(tw_b)    : int'(tw_a);
      obs_ctrl[t]  = sel_b ? int'(ctrl_b)  : int'(ctrl_a);
      obs_eo[t]    = sel_b ? int'(eo_b)    : int'(eo_a);
      obs_stage[t] = sel_b ? int'(stage_b) : int'(stage_a);
      obs_wv[t]    = sel_b ? int'(wrv_b)   : int'(wrv_a);
      obs_wa[t]    = sel_b ? int'(wa_b)    : int'(wa_a);
      obs_busy[t]  = sel_b ? int'(busy_b)  : int'(busy_a);
      obs_done[t]  = sel_b ? int'(done_b)  : int'(done_a);
    end
    @(posedge clk); #1;
    start_a = 1'b0; stall_a = 1'b0; start_b = 1'b0; stall_b = 1'b0;
  endtask

  task automatic test_reset();
    int dc;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, rdv_a, rd_a, tw_a, ctrl_a, eo_a, stage_a, wrv_a, wa_a,
         busy_b, done_b, rdv_b, rd_b, tw_b, ctrl_b, eo_b, stage_b, wrv_b, wa_b} !== '0) begin
      n_fail++; $display("FAIL reset_state: outputs not all zero (a busy=%0b ctrl=%0d)", busy_a, ctrl_a);
    end
    reset_n = 1'b1;
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    build_model(3, 0, dc);
    record_run(3, 0, 3, -1);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, done_a, rdv_a, rd_a, tw_a, ctrl_a, eo_a, stage_a, wrv_a, wa_a} !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy=%0b rdv=%0b rd=%0h stage=%0d wrv=%0b, want all 0",
                         busy_a, rdv_a, rd_a, stage_a, wrv_a);
    end
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 0; last_tw[i] = 0; last_ctrl[i] = 0; last_eo[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || wrv_a !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle cyc %0d: busy=%0b done=%0b wrv=%0b, want 0 0 0",
                           t, busy_a, done_a, wrv_a);
      end
    end
  endtask

  task automatic test_directed_l3();
    int dc, t, ev;
    int e_cyc [12], e_rd [12], e_tw [12], e_ctrl [12];
    e_cyc  = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
    e_rd   = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 1, 3};
    e_tw   = '{0, 2, 1, 3, 0, 0, 2, 2, 0, 0, 0, 0};
    e_ctrl = '{2, 2, 2, 2, 0, 3, 0, 3, 0, 3, 0, 3};
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    build_model(3, 0, dc);
    record_run(3, 0, 26, -1);
    for (int c = 0; c < 26; c++) begin
      ev = ((c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18)) ? 1 : 0;
      n_cmp++;
      if (obs_rv[c] !== ev) begin n_fail++; $display("FAIL l3_rd_valid cyc %0d: got %0d want %0d", c, obs_rv[c], ev); end
      ev = ((c >= 4 && c <= 7) || (c >= 11 && c <= 14) || (c >= 18 && c <= 21)) ? 1 : 0;
      n_cmp++;
      if (obs_wv[c] !== ev) begin n_fail++; $display("FAIL l3_wr_valid cyc %0d: got %0d want %0d", c, obs_wv[c], ev); end
      ev = (c == 22) ? 1 : 0;
      n_cmp++;
      if (obs_done[c] !== ev) begin n_fail++; $display("FAIL l3_done cyc %0d: got %0d want %0d", c, obs_done[c], ev); end
      ev = (c >= 1 && c <= 22) ? 1 : 0;
      n_cmp++;
      if (obs_busy[c] !== ev) begin n_fail++; $display("FAIL l3_busy cyc %0d: got %0d want %0d", c, obs_busy[c], ev); end
    end
    for (int i = 0; i < 12; i++) begin
      t = e_cyc[i];
      n_cmp++;
      if (obs_rd[t] !== e_rd[i] || obs_tw[t] !== e_tw[i] || obs_ctrl[t] !== e_ctrl[i] || obs_wa[t+WB] !== e_rd[i]) begin
        n_fail++;
        $display("FAIL l3_values issue %0d: got rd=%0d tw=%0d ctrl=%0d wa=%0d want rd=%0d tw=%0d ctrl=%0d wa=%0d",
                 i, obs_rd[t], obs_tw[t], obs_ctrl[t], obs_wa[t+WB], e_rd[i], e_tw[i], e_ctrl[i], e_rd[i]);
      end
    end
  endtask

  task automatic test_stall();
    int dc;
    int c_rv [8], e_rv [8], c_wv [6], e_wv [6];
    c_rv = '{8, 9, 10, 11, 12, 13, 17, 20};
    e_rv = '{1, 1, 0, 0, 1, 1, 1, 1};
    c_wv = '{11, 12, 13, 14, 15, 16};
    e_wv = '{1, 1, 0, 0, 1, 1};
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    stall_tab[10] = 1'b1;
    stall_tab[11] = 1'b1;
    build_model(3, 0, dc);
    record_run(3, 0, 28, -1);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs_rv[c_rv[i]] !== e_rv[i]) begin
        n_fail++; $display("FAIL stall_rd_valid cyc %0d: got %0d want %0d", c_rv[i], obs_rv[c_rv[i]], e_rv[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs_wv[c_wv[i]] !== e_wv[i]) begin
        n_fail++; $display("FAIL stall_wr_valid cyc %0d: got %0d want %0d", c_wv[i], obs_wv[c_wv[i]], e_wv[i]);
      end
    end
    n_cmp++;
    if (obs_rd[10] !== 1 || obs_rd[11] !== 1 || obs_rd[12] !== 2 || obs_rd[13] !== 3) begin
      n_fail++; $display("FAIL stall_hold: got rd %0d %0d %0d %0d want 1 1 2 3", obs_rd[10], obs_rd[11], obs_rd[12], obs_rd[13]);
    end
    n_cmp++;
    if (obs_done[22] !== 0 || obs_done[23] !== 0 || obs_done[24] !== 1) begin
      n_fail++; $display("FAIL stall_done: got c22=%0d c23=%0d c24=%0d want 0 0 1", obs_done[22], obs_done[23], obs_done[24]);
    end
  endtask

  task automatic test_no_gap();
    int dc, ev, e_rd [4];
    e_rd = '{0, 1, 0, 1};
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    build_model(2, 1, dc);
    record_run(2, 1, 12, 3);
    for (int c = 0; c < 12; c++) begin
      ev = (c >= 1 && c <= 4) ? 1 : 0;
      n_cmp++;
      if (obs_rv[c] !== ev) begin n_fail++; $display("FAIL nogap_rd_valid cyc %0d: got %0d want %0d", c, obs_rv[c], ev); end
      ev = (c == 8) ? 1 : 0;
      n_cmp++;
      if (obs_done[c] !== ev) begin n_fail++; $display("FAIL nogap_done cyc %0d: got %0d want %0d", c, obs_done[c], ev); end
      ev = (c >= 1 && c <= 8) ? 1 : 0;
      n_cmp++;
      if (obs_busy[c] !== ev) begin n_fail++; $display("FAIL nogap_busy cyc %0d: got %0d want %0d", c, obs_busy[c], ev); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_rd[i+1] !== e_rd[i]) begin n_fail++; $display("FAIL nogap_rd_addr cyc %0d: got %0d want %0d", i + 1, obs_rd[i+1], e_rd[i]); end
    end
  endtask

  task automatic test_max_size();
    int dc;
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    build_model(10, 0, dc);
    record_run(10, 0, 5155, -1);
    n_cmp++;
    if (obs_rv[3075] !== 1 || obs_stage[3075] !== 5 || obs_rd[3075] !== 'h1F9 || obs_tw[3075] !== 'h1E0) begin
      n_fail++; $display("FAIL max_stage5: got rv=%0d stage=%0d rd=%0h tw=%0h want 1 5 1f9 1e0",
                         obs_rv[3075], obs_stage[3075], obs_rd[3075], obs_tw[3075]);
    end
    n_cmp++;
    if (obs_done[5150] !== 0 || obs_done[5151] !== 1) begin
      n_fail++; $display("FAIL max_done: got c5150=%0d c5151=%0d want 0 1", obs_done[5150], obs_done[5151]);
    end
  endtask

  task automatic test_clamp();
    int dc, ev;
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;
    build_model(1, 0, dc);
    record_run(1, 0, 14, -1);
    for (int c = 0; c < 14; c++) begin
      ev = (c == 1 || c == 2 || c == 6 || c == 7) ? 1 : 0;
      n_cmp++;
      if (obs_rv[c] !== ev) begin n_fail++; $display("FAIL clamp_rd_valid cyc %0d: got %0d want %0d", c, obs_rv[c], ev); end
      ev = (c == 11) ? 1 : 0;
      n_cmp++;
      if (obs_done[c] !== ev) begin n_fail++; $display("FAIL clamp_done cyc %0d: got %0d want %0d", c, obs_done[c], ev); end
    end
    n_cmp++;
    if (obs_rd[1] !== 0 || obs_rd[2] !== 1 || obs_rd[6] !== 0 || obs_rd[7] !== 1) begin
      n_fail++; $display("FAIL clamp_rd_addr: got %0d %0d %0d %0d want 0 1 0 1", obs_rd[1], obs_rd[2], obs_rd[6], obs_rd[7]);
    end
  endtask

  task automatic test_random_vs_model();
    int dc, lg, use_b, pct, ev;
    for (int k = 0; k < 6; k++) begin
      use_b = k % 2;
      lg    = (k == 5) ? $urandom_range(11, 15) : $urandom_range(0, 6);
      pct   = (k == 5) ? 10 : $urandom_range(0, 40);
      for (int c = 0; c < MAXC; c++) stall_tab[c] = ($urandom_range(0, 99) < pct);
      build_model(lg, use_b, dc);
      record_run(lg, use_b, dc + 4, -1);
      for (int t = 0; t < dc + 4; t++) begin
        n_cmp++;
        if (obs_rv[t] !== exp_rv[t] || obs_rd[t] !== exp_rd[t] || obs_tw[t] !== exp_tw[t] ||
            obs_ctrl[t] !== exp_ctrl[t] || obs_eo[t] !== exp_eo[t]) begin
          n_fail++;
          $display("FAIL rand_read run %0d cyc %0d: got rv=%0d rd=%0h tw=%0h ctrl=%0d eo=%0d want rv=%0d rd=%0h tw=%0h ctrl=%0d eo=%0d",
                   k, t, obs_rv[t], obs_rd[t], obs_tw[t], obs_ctrl[t], obs_eo[t],
                   exp_rv[t], exp_rd[t], exp_tw[t], exp_ctrl[t], exp_eo[t]);
        end
        if (exp_rv[t] == 1) begin
          n_cmp++;
          if (obs_stage[t] !== exp_stage[t]) begin
            n_fail++; $display("FAIL rand_stage run %0d cyc %0d: got %0d want %0d", k, t, obs_stage[t], exp_stage[t]);
          end
        end
        ev = (t >= 1 && t <= dc) ? 1 : 0;
        n_cmp++;
        if (obs_busy[t] !== ev || obs_done[t] !== ((t == dc) ? 1 : 0)) begin
          n_fail++; $display("FAIL rand_busy_done run %0d cyc %0d: got busy=%0d done=%0d want busy=%0d done=%0d",
                             k, t, obs_busy[t], obs_done[t], ev, (t == dc) ? 1 : 0);
        end
        if (t >= WB) begin
          n_cmp++;
          if (obs_wv[t] !== exp_rv[t-WB] || obs_wa[t] !== exp_rd[t-WB]) begin
            n_fail++; $display("FAIL rand_write run %0d cyc %0d: got wv=%0d wa=%0h want wv=%0d wa=%0h",
                               k, t, obs_wv[t], obs_wa[t], exp_rv[t-WB], exp_rd[t-WB]);
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; sel_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    log2n_a = 4'd0; log2n_b = 4'd0;
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 0; last_tw[i] = 0; last_ctrl[i] = 0; last_eo[i] = 0;
    end
    test_reset();
    test_directed_l3();
    test_stall();
    test_no_gap();
    test_clamp();
    test_max_size();
    test_random_vs_model();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
